// File: rtl/mac_layer_sequencer_pkg.sv
// Shared constants for the MAC layer sequencer: operand width and FSM state encoding.
package mac_seq_pkg;

  localparam int OP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DRAIN0  = 3'd2,
    ST_DRAIN1  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_DONE    = 3'd5
  } seq_state_t;

endpackage

// File: rtl/mac_layer_sequencer_delay.sv
// Aligns the fetch-stage {valid, first} flags with the memory read latency and the MAC's
// internal multiply stage: valid is tapped after one stage, first after two.
module mac_seq_delay (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  input  logic first_in,
  output logic valid_d1,
  output logic first_d2
);

  logic first_d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_d1 <= 1'b0;
      first_d1 <= 1'b0;
      first_d2 <= 1'b0;
    end else begin
      valid_d1 <= valid_in;
      first_d1 <= first_in;
      first_d2 <= first_d1;
    end
  end

endmodule

// File: rtl/mac_layer_sequencer.sv
// Steps one shared MAC through every neuron of a dense layer and writes each finished
// sum to the result buffer. Handshake: start is a level sampled only in IDLE; done pulses once.
module mac_layer_sequencer
  import mac_seq_pkg::*;
#(
  parameter int N_INPUTS  = 8,
  parameter int N_NEURONS = 4,
  parameter int WADDR_W   = (N_INPUTS * N_NEURONS > 1) ? $clog2(N_INPUTS * N_NEURONS) : 1,
  parameter int XADDR_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
  parameter int RADDR_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [WADDR_W-1:0] w_addr,
  input  logic [OP_W-1:0]    w_data,
  output logic [XADDR_W-1:0] x_addr,
  input  logic [OP_W-1:0]    x_data,
  output logic [OP_W-1:0]    mac_weight,
  output logic [OP_W-1:0]    mac_in,
  output logic               mac_forget,
  output logic               mac_oe,
  output logic               mac_reset,
  input  logic [OP_W-1:0]    mac_out,
  output logic [RADDR_W-1:0] res_addr,
  output logic [OP_W-1:0]    res_data,
  output logic               res_we,
  output logic [2:0]         dbg_state
);

  localparam logic [XADDR_W-1:0] I_LAST = XADDR_W'(N_INPUTS - 1);
  localparam logic [RADDR_W-1:0] N_LAST = RADDR_W'(N_NEURONS - 1);

  seq_state_t         state;
  logic [XADDR_W-1:0] i_q;
  logic [RADDR_W-1:0] n_q;
  logic [WADDR_W-1:0] w_addr_q;
  logic               busy_q;
  logic               done_q;
  logic               cap_q;
  logic               fetch;
  logic               first;
  logic               valid_d1;
  logic               first_d2;

  assign fetch = (state == ST_FETCH);
  assign first = fetch && (i_q == '0);

  mac_seq_delay u_delay (
    .clk      (clk),
    .reset    (reset),
    .valid_in (fetch),
    .first_in (first),
    .valid_d1 (valid_d1),
    .first_d2 (first_d2)
  );

  // w_addr runs as its own counter so no multiplier is needed for neuron*N_INPUTS + i.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      i_q      <= '0;
      n_q      <= '0;
      w_addr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cap_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cap_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FETCH;
            i_q      <= '0;
            n_q      <= '0;
            w_addr_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (i_q == I_LAST) begin
            state <= ST_DRAIN0;
          end else begin
            i_q      <= i_q + 1'b1;
            w_addr_q <= w_addr_q + 1'b1;
          end
        end
        ST_DRAIN0: state <= ST_DRAIN1;
        ST_DRAIN1: begin
          state <= ST_CAPTURE;
          cap_q <= 1'b1;
        end
        ST_CAPTURE: begin
          if (n_q != N_LAST) begin
            state    <= ST_FETCH;
            n_q      <= n_q + 1'b1;
            i_q      <= '0;
            w_addr_q <= w_addr_q + 1'b1;
          end else begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operands are zeroed outside valid cycles so the drain cycles accumulate nothing.
  assign mac_weight = valid_d1 ? w_data : '0;
  assign mac_in     = valid_d1 ? x_data : '0;
  assign mac_forget = first_d2;
  assign mac_oe     = cap_q;
  assign mac_reset  = reset;
  assign res_we     = cap_q;
  assign res_data   = cap_q ? mac_out : '0;
  assign res_addr   = n_q;
  assign w_addr     = w_addr_q;
  assign x_addr     = i_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Directed bench: two sequencer configurations, each with its own ROM, input buffer and
// two-stage MAC model; observed events are logged per cycle and checked against expected queues.
module tb_mac_layer_sequencer;

  typedef logic [31:0] word_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Configuration A: N_INPUTS=4, N_NEURONS=2
  logic       a_start, a_busy, a_done, a_forget, a_oe, a_mreset, a_we;
  logic [2:0] a_w_addr, a_state;
  logic [1:0] a_x_addr;
  logic [0:0] a_res_addr;
  logic [7:0] a_wd = '0, a_xd = '0, a_mw, a_mi, a_mout, a_rdata, a_prod, a_acc;
  logic [7:0] a_rom [8];
  logic [7:0] a_xb  [4];

  mac_layer_sequencer #(.N_INPUTS(4), .N_NEURONS(2)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
    .w_addr(a_w_addr), .w_data(a_wd), .x_addr(a_x_addr), .x_data(a_xd),
    .mac_weight(a_mw), .mac_in(a_mi), .mac_forget(a_forget), .mac_oe(a_oe),
    .mac_reset(a_mreset), .mac_out(a_mout), .res_addr(a_res_addr), .res_data(a_rdata),
    .res_we(a_we), .dbg_state(a_state)
  );

  always @(posedge clk) begin
    a_wd <= a_rom[a_w_addr];
    a_xd <= a_xb[a_x_addr];
    if (a_mreset) begin
      a_prod <= '0;
      a_acc  <= '0;
    end else begin
      a_prod <= a_mw * a_mi;
      a_acc  <= a_forget ? a_prod : a_acc + a_prod;
    end
  end
  assign a_mout = a_oe ? a_acc : 8'd0;

  // Configuration B: N_INPUTS=1, N_NEURONS=3
  logic       b_start, b_busy, b_done, b_forget, b_oe, b_mreset, b_we;
  logic [1:0] b_w_addr, b_res_addr;
  logic [2:0] b_state;
  logic [0:0] b_x_addr;
  logic [7:0] b_wd = '0, b_xd = '0, b_mw, b_mi, b_mout, b_rdata, b_prod, b_acc;
  logic [7:0] b_rom [4];
  logic [7:0] b_xb  [2];

  mac_layer_sequencer #(.N_INPUTS(1), .N_NEURONS(3)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .w_addr(b_w_addr), .w_data(b_wd), .x_addr(b_x_addr), .x_data(b_xd),
    .mac_weight(b_mw), .mac_in(b_mi), .mac_forget(b_forget), .mac_oe(b_oe),
    .mac_reset(b_mreset), .mac_out(b_mout), .res_addr(b_res_addr), .res_data(b_rdata),
    .res_we(b_we), .dbg_state(b_state)
  );

  always @(posedge clk) begin
    b_wd <= b_rom[b_w_addr];
    b_xd <= b_xb[b_x_addr];
    if (b_mreset) begin
      b_prod <= '0;
      b_acc  <= '0;
    end else begin
      b_prod <= b_mw * b_mi;
      b_acc  <= b_forget ? b_prod : b_acc + b_prod;
    end
  end
  assign b_mout = b_oe ? b_acc : 8'd0;

  // Observed and expected event logs (cycle numbers, addresses, data)
  word_t obs_wc[$], obs_wa[$], obs_wd[$], obs_done[$], obs_fg[$], obs_busy[$];
  word_t exp_wc[$], exp_wa[$], exp_wd[$], exp_done[$], exp_fg[$], exp_busy[$];

  always @(negedge clk) begin
    if (a_we) begin
      obs_wc.push_back(32'(cyc));
      obs_wa.push_back(32'(a_res_addr));
      obs_wd.push_back(32'(a_rdata));
    end
    if (b_we) begin
      obs_wc.push_back(32'(cyc));
      obs_wa.push_back(32'(b_res_addr));
      obs_wd.push_back(32'(b_rdata));
    end
    if (a_done || b_done) obs_done.push_back(32'(cyc));
    if (a_forget || b_forget) obs_fg.push_back(32'(cyc));
    if (a_busy || b_busy) obs_busy.push_back(32'(cyc));
  end

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input word_t obs[$], input word_t exp[$]);
    chk({tag, "_count"}, 32'(obs.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      if (k < obs.size()) chk($sformatf("%s[%0d]", tag, k), obs[k], exp[k]);
    end
  endtask

  task automatic cmp_all(input string tag);
    cmp_q({tag, "_wr_cycle"}, obs_wc, exp_wc);
    cmp_q({tag, "_wr_addr"}, obs_wa, exp_wa);
    cmp_q({tag, "_wr_data"}, obs_wd, exp_wd);
    cmp_q({tag, "_done_cycle"}, obs_done, exp_done);
    cmp_q({tag, "_forget_cycle"}, obs_fg, exp_fg);
    cmp_q({tag, "_busy_cycle"}, obs_busy, exp_busy);
    obs_wc.delete(); obs_wa.delete(); obs_wd.delete();
    obs_done.delete(); obs_fg.delete(); obs_busy.delete();
    exp_wc.delete(); exp_wa.delete(); exp_wd.delete();
    exp_done.delete(); exp_fg.delete(); exp_busy.delete();
  endtask

  // Expected timing of a full, undisturbed layer started in cycle s
  task automatic exp_run(input int s, input int n, input int m);
    for (int k = 1; k <= m * (n + 3); k++) exp_busy.push_back(32'(s + k));
    for (int j = 0; j < m; j++) begin
      exp_fg.push_back(32'(s + 1 + j * (n + 3) + 2));
      exp_wc.push_back(32'(s + (j + 1) * (n + 3)));
      exp_wa.push_back(32'(j));
    end
    exp_done.push_back(32'(s + 1 + m * (n + 3)));
  endtask

  task automatic start_a(output int s);
    @(negedge clk);
    s = cyc;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  int s, s2;

  initial begin
    reset = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    for (int k = 0; k < 8; k++) a_rom[k] = 8'd0;
    for (int k = 0; k < 4; k++) a_xb[k] = 8'd0;
    for (int k = 0; k < 4; k++) b_rom[k] = 8'd0;
    for (int k = 0; k < 2; k++) b_xb[k] = 8'd0;
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_res_we", 32'(a_we), 0);
    chk("rst_mac_oe", 32'(a_oe), 0);
    chk("rst_mac_forget", 32'(a_forget), 0);
    chk("rst_mac_weight", 32'(a_mw), 0);
    chk("rst_mac_in", 32'(a_mi), 0);
    chk("rst_w_addr", 32'(a_w_addr), 0);
    chk("rst_x_addr", 32'(a_x_addr), 0);
    chk("rst_res_addr", 32'(a_res_addr), 0);
    chk("rst_res_data", 32'(a_rdata), 0);
    chk("rst_mac_reset", 32'(a_mreset), 1);
    chk("rst_state", 32'(a_state), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("run_mac_reset", 32'(a_mreset), 0);
    chk("idle_busy", 32'(a_busy), 0);

    // A1: neuron 0 weights 1, neuron 1 weights 2, x = 1..4
    for (int k = 0; k < 4; k++) begin
      a_rom[k]     = 8'd1;
      a_rom[k + 4] = 8'd2;
      a_xb[k]      = 8'(k + 1);
    end
    start_a(s);
    exp_run(s, 4, 2);
    exp_wd.push_back(10); exp_wd.push_back(20);
    repeat (20) @(negedge clk);
    cmp_all("basic");

    // A2: stale sum of 50 must not leak into neuron 1
    for (int k = 0; k < 4; k++) begin
      a_rom[k]     = 8'd5;
      a_rom[k + 4] = 8'd0;
    end
    start_a(s);
    exp_run(s, 4, 2);
    exp_wd.push_back(50); exp_wd.push_back(0);
    repeat (20) @(negedge clk);
    cmp_all("no_carry");

    // A3: 100*3*4 = 1200 wraps to 176; neuron 1 = 1*3*4 = 12
    for (int k = 0; k < 4; k++) begin
      a_rom[k]     = 8'd100;
      a_rom[k + 4] = 8'd1;
      a_xb[k]      = 8'd3;
    end
    start_a(s);
    exp_run(s, 4, 2);
    exp_wd.push_back(176); exp_wd.push_back(12);
    repeat (20) @(negedge clk);
    cmp_all("wrap");

    // A4: reset during neuron 1 FETCH (cycle s+9), then a clean rerun of A1
    for (int k = 0; k < 4; k++) begin
      a_rom[k]     = 8'd1;
      a_rom[k + 4] = 8'd2;
      a_xb[k]      = 8'(k + 1);
    end
    start_a(s);
    repeat (8) @(negedge clk);
    chk("pre_reset_state", 32'(a_state), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("post_reset_state", 32'(a_state), 0);
    for (int k = 1; k <= 9; k++) exp_busy.push_back(32'(s + k));
    exp_fg.push_back(32'(s + 3));
    exp_wc.push_back(32'(s + 7)); exp_wa.push_back(0); exp_wd.push_back(10);
    repeat (20) @(negedge clk);
    cmp_all("mid_reset");

    start_a(s);
    exp_run(s, 4, 2);
    exp_wd.push_back(10); exp_wd.push_back(20);
    repeat (20) @(negedge clk);
    cmp_all("after_reset");

    // A5: start pulse while busy is ignored; start held through DONE is taken in IDLE
    start_a(s);
    repeat (4) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (9) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_start = 1'b0;
    s2 = s + 16;
    exp_run(s, 4, 2);
    exp_run(s2, 4, 2);
    exp_wd.push_back(10); exp_wd.push_back(20);
    exp_wd.push_back(10); exp_wd.push_back(20);
    repeat (25) @(negedge clk);
    cmp_all("start_rules");

    // B: N=1, M=3, weights 7,8,9, x=2
    b_rom[0] = 8'd7; b_rom[1] = 8'd8; b_rom[2] = 8'd9;
    b_xb[0] = 8'd2;
    @(negedge clk);
    s = cyc;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    exp_run(s, 1, 3);
    exp_wd.push_back(14); exp_wd.push_back(16); exp_wd.push_back(18);
    repeat (20) @(negedge clk);
    cmp_all("single_input");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
